// File: rtl/xb_info_scan_ctrl.sv
// XB_INFO scan sequencer: signature check, entry count, entry streaming.
// Optional grant-wait timeout enabled by XB_INFO_SCAN_TIMEOUT_EN.
module xb_info_scan_ctrl #(
  parameter logic [7:0] INFO_ADDR  = 8'hFF,
  parameter logic [7:0] VALID_ADDR = 8'hFC,
  parameter logic [7:0] SIG0       = 8'h88,
  parameter logic [7:0] SIG1       = 8'h76,
  parameter logic [7:0] SIG2       = 8'h82,
  parameter logic [7:0] SIG3       = 8'h56,
  parameter logic [7:0] MAX_ENT    = 8'd16
`ifdef XB_INFO_SCAN_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       sig_ok,
  output logic       err,
  output logic [7:0] num_entries,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [7:0] ramadr,
  output logic       ramre,
  output logic       ramwe,
  output logic [7:0] dbus_wr,
  input  logic [7:0] dbus_rd,
  output logic       ent_valid,
  input  logic       ent_ready,
  output logic [7:0] ent_addr,
  output logic [7:0] ent_data
);

  typedef enum logic [3:0] {
    IDLE, REQ, WR_SIG, RD_SIG, WR_BASE,
    RD_NUM, RD_ENT, OUT, FIN
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sig_idx_q, sig_idx_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  ent_addr_q, ent_addr_d;
  logic [7:0]  ent_data_q, ent_data_d;
  logic [7:0]  num_q, num_d;
  logic        sig_ok_q, sig_ok_d;
  logic        err_q, err_d;
  logic [7:0]  sig_exp;

`ifdef XB_INFO_SCAN_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic        pend;

  assign pend = (state_q == WR_SIG) || (state_q == RD_SIG)
             || (state_q == WR_BASE) || (state_q == RD_NUM)
             || (state_q == RD_ENT);
`endif

  always_comb begin
    unique case (sig_idx_q)
      2'd0: sig_exp = SIG0;
      2'd1: sig_exp = SIG1;
      2'd2: sig_exp = SIG2;
      2'd3: sig_exp = SIG3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sig_idx_d  = sig_idx_q;
    k_d        = k_q;
    n_d        = n_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    num_d      = num_q;
    sig_ok_d   = sig_ok_q;
    err_d      = err_q;
    bus_req    = 1'b0;
    ramre      = 1'b0;
    ramwe      = 1'b0;
    ramadr     = 8'h00;
    dbus_wr    = 8'h00;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sig_ok_d = 1'b0;
          err_d    = 1'b0;
          num_d    = 8'h00;
          state_d  = REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        state_d = WR_SIG;
      end
      WR_SIG: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          ramwe     = 1'b1;
          ramadr    = INFO_ADDR;
          dbus_wr   = VALID_ADDR;
          sig_idx_d = 2'd0;
          state_d   = RD_SIG;
        end
      end
      RD_SIG: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          ramre  = 1'b1;
          ramadr = INFO_ADDR;
          if (dbus_rd != sig_exp) begin
            err_d    = 1'b1;
            sig_ok_d = 1'b0;
            state_d  = FIN;
          end else if (sig_idx_q == 2'd3) begin
            sig_ok_d = 1'b1;
            state_d  = WR_BASE;
          end else begin
            sig_idx_d = sig_idx_q + 2'd1;
          end
        end
      end
      WR_BASE: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          ramwe   = 1'b1;
          ramadr  = INFO_ADDR;
          state_d = RD_NUM;
        end
      end
      RD_NUM: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          ramre  = 1'b1;
          ramadr = INFO_ADDR;
          num_d  = dbus_rd;
          k_d    = 8'd1;
          if (dbus_rd == 8'd0) begin
            state_d = FIN;
          end else if (dbus_rd > MAX_ENT) begin
            err_d   = 1'b1;
            n_d     = MAX_ENT;
            state_d = RD_ENT;
          end else begin
            n_d     = dbus_rd;
            state_d = RD_ENT;
          end
        end
      end
      RD_ENT: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          ramre      = 1'b1;
          ramadr     = INFO_ADDR;
          ent_data_d = dbus_rd;
          ent_addr_d = k_q;
          state_d    = OUT;
        end
      end
      OUT: begin
        bus_req = 1'b1;
        if (ent_ready) begin
          if (k_q == n_q) begin
            state_d = FIN;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = RD_ENT;
          end
        end
      end
      FIN: begin
        done = 1'b1;
        // A start coinciding with done begins the next scan directly.
        if (start) begin
          sig_ok_d = 1'b0;
          err_d    = 1'b0;
          num_d    = 8'h00;
          state_d  = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef XB_INFO_SCAN_TIMEOUT_EN
    to_d = 16'd0;
    if (pend && !bus_gnt) begin
      if (to_q == 16'(TIMEOUT_CYC - 16'd1)) begin
        err_d   = 1'b1;
        state_d = FIN;
      end else begin
        to_d = to_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sig_idx_q  <= 2'd0;
      k_q        <= 8'd0;
      n_q        <= 8'd0;
      ent_addr_q <= 8'd0;
      ent_data_q <= 8'd0;
      num_q      <= 8'd0;
      sig_ok_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_idx_q  <= sig_idx_d;
      k_q        <= k_d;
      n_q        <= n_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      num_q      <= num_d;
      sig_ok_q   <= sig_ok_d;
      err_q      <= err_d;
    end
  end

`ifdef XB_INFO_SCAN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) to_q <= 16'd0;
    else       to_q <= to_d;
  end
`endif

  assign busy        = (state_q != IDLE);
  assign ent_valid   = (state_q == OUT);
  assign ent_addr    = ent_addr_q;
  assign ent_data    = ent_data_q;
  assign sig_ok      = sig_ok_q;
  assign err         = err_q;
  assign num_entries = num_q;

endmodule
